step_counter_scan: RTL and testbench

//  N-digit BCD stepping counter with selectable even/odd start, up/down

---
 rtl/step_counter_scan_pkg.sv | 46 ++++
 rtl/step_counter_scan_seg7_decode.sv | 30 +++
 rtl/step_counter_scan.sv | 115 +++++++++++
 tb/tb_step_counter_scan.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/step_counter_scan_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_counter_scan_pkg : segment constants and BCD digit step helper
// Revision 1.0
// ---------------------------------------------------------------------------
package step_counter_scan_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [0:6] seg_t;

    // Segment order a..g, active-low (0 = lit)
    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001101;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Returns {carry/borrow out, result digit}
    function automatic logic [4:0] bcd_step(input bcd_digit_t d, input logic [3:0] s,
                                            input logic cin, input logic down);
        logic [4:0] t;
        if (!down) begin
            t = {1'b0, d} + {1'b0, s} + {4'b0000, cin};
            if (t >= 5'd10) begin
                t = t - 5'd10;
                return {1'b1, t[3:0]};
            end
            return {1'b0, t[3:0]};
        end else begin
            t = {1'b0, d} - {1'b0, s} - {4'b0000, cin};
            if (t[4]) begin
                t = t + 5'd10;
                return {1'b1, t[3:0]};
            end
            return {1'b0, t[3:0]};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_counter_scan_seg7_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_counter_scan_seg7_decode : BCD digit to active-low a..g segments
// Revision 1.0
// ---------------------------------------------------------------------------
module step_counter_scan_seg7_decode (
    input  logic [3:0] digit_i,
    output logic [0:6] seg_o
);
    import step_counter_scan_pkg::*;

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/step_counter_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_counter_scan : N-digit BCD even/odd stepping counter, scanned 7-seg
// Revision 1.0
// ---------------------------------------------------------------------------
module step_counter_scan #(
    parameter int N_DIGITS = 4,
    parameter int STEP     = 2,
    parameter int TICK_DIV = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eo,
    input  logic                  dir,
    input  logic                  en,
    output logic [4*N_DIGITS-1:0] count_bcd,
    output logic                  wrap,
    output logic [0:6]            led,
    output logic [N_DIGITS-1:0]   an
);
    import step_counter_scan_pkg::*;

    localparam int         CW         = 4 * N_DIGITS;
    localparam int         PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int         SW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int         IW         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [3:0] STEP_DIGIT = 4'(STEP);

    logic                eo_q;
    logic [PW-1:0]       presc_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                carry_d;
    logic                wrap_q;
    logic [SW-1:0]       scan_div_q;
    logic [IW-1:0]       scan_idx_q;
    logic [0:6]          led_q;
    logic [N_DIGITS-1:0] an_q;
    logic                reload_w;
    logic                tick_w;
    bcd_digit_t          digit_w;
    seg_t                seg_w;

    assign reload_w = (eo != eo_q);
    assign tick_w   = en && (presc_q == PW'(TICK_DIV - 1));

    // Ripple the step through the digits; only digit 0 receives STEP itself
    always_comb begin
        logic [4:0] r;
        logic       c;
        count_d = '0;
        c       = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            r = bcd_step(count_q[4*i +: 4], (i == 0) ? STEP_DIGIT : 4'd0, c, dir);
            count_d[4*i +: 4] = r[3:0];
            c = r[4];
        end
        carry_d = c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eo_q    <= 1'b0;
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            eo_q   <= eo;
            wrap_q <= 1'b0;
            if (reload_w) begin
                count_q <= {{(CW-1){1'b0}}, eo};
                presc_q <= '0;
            end else if (tick_w) begin
                count_q <= count_d;
                wrap_q  <= carry_d;
                presc_q <= '0;
            end else if (en) begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign digit_w = count_q[{scan_idx_q, 2'b00} +: 4];

    step_counter_scan_seg7_decode u_seg7_decode (
        .digit_i (digit_w),
        .seg_o   (seg_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_div_q <= '0;
            scan_idx_q <= '0;
            led_q      <= SEG_0;
            an_q       <= ~N_DIGITS'(1);
        end else begin
            led_q <= seg_w;
            an_q  <= ~(N_DIGITS'(1) << scan_idx_q);
            if (scan_div_q == SW'(SCAN_DIV - 1)) begin
                scan_div_q <= '0;
                scan_idx_q <= (scan_idx_q == IW'(N_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
            end else begin
                scan_div_q <= scan_div_q + 1'b1;
            end
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;
    assign led       = led_q;
    assign an        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_step_counter_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_step_counter_scan : two configurations checked against an integer model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_step_counter_scan;

    localparam int PN    [2] = '{2, 4};
    localparam int PSTEP [2] = '{2, 2};
    localparam int PTICK [2] = '{1, 3};
    localparam int PSCAN [2] = '{4, 4};
    localparam int PMOD  [2] = '{100, 10000};
    localparam int SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                                    7'b0000000, 7'b0000100};

    logic        clk, reset, eo, dir, en;
    logic [7:0]  count_a;
    logic [15:0] count_b;
    logic        wrap_a, wrap_b;
    logic [0:6]  led_a, led_b;
    logic [1:0]  an_a;
    logic [3:0]  an_b;

    int n_cmp = 0;
    int n_mis = 0;

    int m_cnt [2];
    int m_pre [2];
    int m_wrap[2];
    int m_led [2];
    int m_an  [2];
    int m_eo, m_t;

    step_counter_scan #(.N_DIGITS(2), .STEP(2), .TICK_DIV(1), .SCAN_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .eo(eo), .dir(dir), .en(en),
        .count_bcd(count_a), .wrap(wrap_a), .led(led_a), .an(an_a));

    step_counter_scan #(.N_DIGITS(4), .STEP(2), .TICK_DIV(3), .SCAN_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .eo(eo), .dir(dir), .en(en),
        .count_bcd(count_b), .wrap(wrap_b), .led(led_b), .an(an_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int          x = v;
        for (int d = 0; d < n; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_pre[i]  = 0;
            m_wrap[i] = 0;
            m_led[i]  = SEG_TAB[0];
            m_an[i]   = ((1 << PN[i]) - 1) & ~1;
        end
        m_eo = 0;
        m_t  = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        int idx, nv;
        for (int i = 0; i < 2; i++) begin
            idx       = (m_t / PSCAN[i]) % PN[i];
            m_led[i]  = SEG_TAB[(m_cnt[i] / pow10(idx)) % 10];
            m_an[i]   = ((1 << PN[i]) - 1) & ~(1 << idx);
            m_wrap[i] = 0;
            if (int'(eo) != m_eo) begin
                m_cnt[i] = int'(eo);
                m_pre[i] = 0;
            end else if (en) begin
                if (m_pre[i] == PTICK[i] - 1) begin
                    m_pre[i]  = 0;
                    nv        = dir ? m_cnt[i] - PSTEP[i] : m_cnt[i] + PSTEP[i];
                    m_wrap[i] = (nv < 0 || nv >= PMOD[i]) ? 1 : 0;
                    m_cnt[i]  = (nv + PMOD[i]) % PMOD[i];
                end else begin
                    m_pre[i]++;
                end
            end
        end
        m_t++;
        m_eo = int'(eo);
    endtask

    task automatic check_all();
        chk("A.count", 32'(count_a), to_bcd(m_cnt[0], 2));
        chk("A.wrap",  32'(wrap_a),  32'(m_wrap[0]));
        chk("A.led",   32'(led_a),   32'(m_led[0]));
        chk("A.an",    32'(an_a),    32'(m_an[0]));
        chk("B.count", 32'(count_b), to_bcd(m_cnt[1], 4));
        chk("B.wrap",  32'(wrap_b),  32'(m_wrap[1]));
        chk("B.led",   32'(led_b),   32'(m_led[1]));
        chk("B.an",    32'(an_b),    32'(m_an[1]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; eo = 1'b0; dir = 1'b0; en = 1'b1;
        #1;

        // Even up-count with wrap 98 -> 0
        do_reset();
        chk("t1_reset_led", 32'(led_a), 32'(7'b0000001));
        chk("t1_reset_an",  32'(an_b),  32'(4'b1110));
        for (int k = 0; k < 49; k++) step();
        chk("t1_at98", 32'(count_a), 32'h98);
        step();
        chk("t1_wrap0", 32'(count_a), 32'h00);
        chk("t1_wrap1", 32'(wrap_a), 32'd1);
        step();
        chk("t1_wrap_pulse", 32'(wrap_a), 32'd0);

        // Odd mode held through reset
        eo = 1'b1;
        do_reset();
        step();
        chk("t2_first", 32'(count_a), 32'h01);
        for (int k = 0; k < 50; k++) step();
        chk("t2_wrap_cnt", 32'(count_a), 32'h01);

        // Reload beats a due tick
        eo = 1'b0;
        do_reset();
        for (int k = 0; k < 23; k++) step();
        chk("t3_at46", 32'(count_a), 32'h46);
        eo = 1'b1;
        step();
        chk("t3_reload", 32'(count_a), 32'h01);
        chk("t3_nowrap", 32'(wrap_a), 32'd0);
        step();
        chk("t3_next", 32'(count_a), 32'h03);

        // Down count across zero, then hold with en low
        eo = 1'b0; dir = 1'b1;
        do_reset();
        step();
        chk("t4_down98", 32'(count_a), 32'h98);
        chk("t4_wrap",   32'(wrap_a),  32'd1);
        step();
        chk("t4_down96", 32'(count_a), 32'h96);
        en = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("t4_hold", 32'(count_a), 32'h96);

        // TICK_DIV = 3 with en pattern 1,0,1,1
        dir = 1'b0; en = 1'b1;
        do_reset();
        step();
        en = 1'b0; step();
        en = 1'b1; step();
        chk("t5_notyet", 32'(count_b), 32'h0000);
        step();
        chk("t5_tick", 32'(count_b), 32'h0002);

        // Reach 1357 on the 4-digit instance, freeze and watch the scan
        eo = 1'b1;
        do_reset();
        for (int k = 0; k < 3000 && m_cnt[1] != 1357; k++) step();
        chk("t6_reach", 32'(count_b), 32'h1357);
        en = 1'b0;
        for (int k = 0; k < 24; k++) step();

        // Random traffic including asynchronous resets
        en = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(15) == 0) eo = ~eo;
            if ($urandom_range(31) == 0) dir = ~dir;
            en = ($urandom_range(3) != 0);
            if ($urandom_range(299) == 0) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
